// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the 8-bit RISC core: opcodes, ALU select codes, FSM states, field positions.
package cpu_defs_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_LDI  = 4'h5;
  localparam logic [3:0] OP_BRZ  = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h7;
  localparam logic [3:0] OP_NOP  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  // ALU select codes are numerically equal to the ALU opcodes.
  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_OR   = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_IDLE = 4'h0;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 10;
  localparam int RS1_MSB = 9;
  localparam int RS1_LSB = 8;
  localparam int RS2_MSB = 7;
  localparam int RS2_LSB = 6;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WB,
    ST_HALT
  } state_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode classifier. CTRL_BRANCH_EN enables BRZ/JMP; otherwise ops 6/7 decode as illegal.
module instr_decoder
  import cpu_defs_pkg::*;
(
  input  logic [3:0] op,
  output logic [3:0] alu_sel,
  output logic       is_alu,
  output logic       is_ldi,
  output logic       is_brz,
  output logic       is_jmp,
  output logic       is_halt,
  output logic       illegal
);

  always_comb begin
    alu_sel = ALU_IDLE;
    is_alu  = 1'b0;
    is_ldi  = 1'b0;
    is_brz  = 1'b0;
    is_jmp  = 1'b0;
    is_halt = 1'b0;
    illegal = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
        is_alu  = 1'b1;
        alu_sel = op;
      end
      OP_LDI:  is_ldi = 1'b1;
`ifdef CTRL_BRANCH_EN
      OP_BRZ:  is_brz = 1'b1;
      OP_JMP:  is_jmp = 1'b1;
`endif
      OP_NOP:  ;
      OP_HALT: is_halt = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle control FSM: fetch over req/ack, decode, exec, write-back; PC and zero flag live here.
// Branch support (BRZ/JMP) is selected by CTRL_BRANCH_EN inside instr_decoder.
module cpu_control_unit
  import cpu_defs_pkg::*;
#(
  parameter int              INSTR_W  = 16,
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               IMem_Req,
  output logic [PC_W-1:0]    IMem_Addr,
  input  logic               IMem_Ack,
  input  logic [INSTR_W-1:0] IMem_Data,
  output logic [1:0]         RS1_Addr,
  output logic [1:0]         RS2_Addr,
  output logic [1:0]         RD_Addr,
  output logic               RF_WE,
  output logic               WB_Sel,
  output logic [7:0]         Imm,
  output logic [3:0]         ALU_Sel,
  input  logic               ALU_Zero,
  output logic               Zero_Flag,
  output logic               Halted,
  output logic               Illegal
);

  state_t              state_q, state_d;
  logic [INSTR_W-1:0]  ir_q;
  logic [PC_W-1:0]     pc_q;
  logic                zf_q;
  logic                started_q;

  logic [3:0] dec_alu_sel;
  logic       is_alu, is_ldi, is_brz, is_jmp, is_halt, dec_illegal;
  logic       fetch_done, take_branch;

  instr_decoder u_dec (
    .op      (ir_q[OP_MSB:OP_LSB]),
    .alu_sel (dec_alu_sel),
    .is_alu  (is_alu),
    .is_ldi  (is_ldi),
    .is_brz  (is_brz),
    .is_jmp  (is_jmp),
    .is_halt (is_halt),
    .illegal (dec_illegal)
  );

  assign fetch_done  = IMem_Req && IMem_Ack;
  assign take_branch = (state_q == ST_EXEC) && (is_jmp || (is_brz && zf_q));

  // started_q keeps IMem_Req low until the first edge after reset release,
  // so an Ack still high from before reset can never be taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      zf_q      <= 1'b0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      started_q <= 1'b1;
      if (fetch_done) begin
        ir_q <= IMem_Data;
        pc_q <= pc_q + PC_W'(1);
      end else if (take_branch) begin
        pc_q <= PC_W'(ir_q[IMM_MSB:IMM_LSB]);
      end
      if (state_q == ST_EXEC && is_alu) zf_q <= ALU_Zero;
    end
  end

  always_comb begin
    state_d  = state_q;
    IMem_Req = 1'b0;
    RF_WE    = 1'b0;
    WB_Sel   = 1'b0;
    ALU_Sel  = ALU_IDLE;
    Halted   = 1'b0;
    Illegal  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        IMem_Req = started_q;
        if (started_q && IMem_Ack) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (dec_illegal) begin
          Illegal = 1'b1;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (is_alu) ALU_Sel = dec_alu_sel;
        if (is_halt)                state_d = ST_HALT;
        else if (is_alu || is_ldi)  state_d = ST_WB;
        else                        state_d = ST_FETCH;
      end
      ST_WB: begin
        RF_WE   = 1'b1;
        WB_Sel  = is_ldi;
        state_d = ST_FETCH;
      end
      ST_HALT: Halted = 1'b1;
      default: state_d = ST_FETCH;
    endcase
  end

  assign IMem_Addr = pc_q;
  assign RS1_Addr  = ir_q[RS1_MSB:RS1_LSB];
  assign RS2_Addr  = ir_q[RS2_MSB:RS2_LSB];
  assign RD_Addr   = ir_q[RD_MSB:RD_LSB];
  assign Imm       = ir_q[IMM_MSB:IMM_LSB];
  assign Zero_Flag = zf_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit; expectations follow CTRL_BRANCH_EN when it is defined.
module tb_cpu_control_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        IMem_Req;
  logic [7:0]  IMem_Addr;
  logic        IMem_Ack = 1'b0;
  logic [15:0] IMem_Data = 16'h0000;
  logic [1:0]  RS1_Addr, RS2_Addr, RD_Addr;
  logic        RF_WE, WB_Sel;
  logic [7:0]  Imm;
  logic [3:0]  ALU_Sel;
  logic        ALU_Zero = 1'b0;
  logic        Zero_Flag, Halted, Illegal;

  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] pc;

  cpu_control_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .IMem_Req  (IMem_Req),
    .IMem_Addr (IMem_Addr),
    .IMem_Ack  (IMem_Ack),
    .IMem_Data (IMem_Data),
    .RS1_Addr  (RS1_Addr),
    .RS2_Addr  (RS2_Addr),
    .RD_Addr   (RD_Addr),
    .RF_WE     (RF_WE),
    .WB_Sel    (WB_Sel),
    .Imm       (Imm),
    .ALU_Sel   (ALU_Sel),
    .ALU_Zero  (ALU_Zero),
    .Zero_Flag (Zero_Flag),
    .Halted    (Halted),
    .Illegal   (Illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!IMem_Req && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_req_timeout"}, IMem_Req, 1);
  endtask

  // Returns at the negedge inside DECODE.
  task automatic fetch(input logic [15:0] instr, input int waits, input string tag);
    wait_req(tag);
    check({tag, "_addr"}, IMem_Addr, pc);
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      check({tag, "_req_hold"}, IMem_Req, 1);
      check({tag, "_addr_hold"}, IMem_Addr, pc);
    end
    IMem_Data = instr;
    IMem_Ack  = 1'b1;
    @(negedge clk);
    IMem_Ack  = 1'b0;
    IMem_Data = 16'h0000;
    pc = pc + 8'd1;
  endtask

  task automatic alu_op(input logic [15:0] instr, input int waits, input logic zin,
                        input logic [1:0] rd, input logic [1:0] rs1, input logic [1:0] rs2,
                        input logic [3:0] sel, input string tag);
    fetch(instr, waits, tag);
    check({tag, "_dec_illegal"}, Illegal, 0);
    check({tag, "_dec_rs1"}, RS1_Addr, rs1);
    check({tag, "_dec_rs2"}, RS2_Addr, rs2);
    check({tag, "_dec_we"}, RF_WE, 0);
    ALU_Zero = zin;
    @(negedge clk);
    check({tag, "_exec_sel"}, ALU_Sel, sel);
    check({tag, "_exec_we"}, RF_WE, 0);
    @(negedge clk);
    ALU_Zero = ~zin;
    check({tag, "_wb_we"}, RF_WE, 1);
    check({tag, "_wb_sel"}, WB_Sel, 0);
    check({tag, "_wb_rd"}, RD_Addr, rd);
    check({tag, "_wb_zf"}, Zero_Flag, zin);
    check({tag, "_wb_alusel"}, ALU_Sel, 0);
    @(negedge clk);
    check({tag, "_post_we"}, RF_WE, 0);
    check({tag, "_post_zf"}, Zero_Flag, zin);
  endtask

  task automatic flow_op(input logic [15:0] instr, input logic exp_ill,
                         input logic [7:0] exp_next, input string tag);
    fetch(instr, 0, tag);
    check({tag, "_dec_illegal"}, Illegal, exp_ill);
    if (!exp_ill) begin
      @(negedge clk);
      check({tag, "_exec_sel"}, ALU_Sel, 0);
      check({tag, "_exec_we"}, RF_WE, 0);
    end
    @(negedge clk);
    check({tag, "_illegal_clr"}, Illegal, 0);
    check({tag, "_we"}, RF_WE, 0);
    check({tag, "_next_req"}, IMem_Req, 1);
    check({tag, "_next_addr"}, IMem_Addr, exp_next);
    pc = exp_next;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic br;
    int   req_cnt;
    int   we_cnt;
`ifdef CTRL_BRANCH_EN
    br = 1'b1;
`else
    br = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_req", IMem_Req, 0);
    check("rst_addr", IMem_Addr, 8'h00);
    check("rst_we", RF_WE, 0);
    check("rst_wbsel", WB_Sel, 0);
    check("rst_alusel", ALU_Sel, 0);
    check("rst_zf", Zero_Flag, 0);
    check("rst_halted", Halted, 0);
    check("rst_illegal", Illegal, 0);
    check("rst_rd", RD_Addr, 0);
    check("rst_rs1", RS1_Addr, 0);
    check("rst_rs2", RS2_Addr, 0);
    check("rst_imm", Imm, 0);

    rst_n = 1'b1;
    pc    = 8'h00;
    @(negedge clk);
    check("req_after_release", IMem_Req, 1);

    // ADD r0,r0,r0 with two wait cycles, then XOR r1,r2,r3 setting the flag
    alu_op(16'h0000, 2, 1'b0, 2'd0, 2'd0, 2'd0, 4'h0, "add");
    check("add_next_addr", IMem_Addr, 8'h01);
    alu_op(16'h46C0, 0, 1'b1, 2'd1, 2'd2, 2'd3, 4'h4, "xor");

    // LDI r2,#5A; flag must survive with ALU_Zero low
    fetch(16'h585A, 0, "ldi");
    check("ldi_dec_illegal", Illegal, 0);
    ALU_Zero = 1'b0;
    @(negedge clk);
    check("ldi_exec_sel", ALU_Sel, 0);
    @(negedge clk);
    check("ldi_wb_we", RF_WE, 1);
    check("ldi_wb_sel", WB_Sel, 1);
    check("ldi_wb_rd", RD_Addr, 2'd2);
    check("ldi_wb_imm", Imm, 8'h5A);
    check("ldi_wb_zf", Zero_Flag, 1);
    @(negedge clk);
    check("ldi_post_we", RF_WE, 0);
    check("ldi_post_zf", Zero_Flag, 1);

    alu_op(16'h1000, 0, 1'b1, 2'd0, 2'd0, 2'd0, 4'h1, "sub_z1");
    flow_op(16'h6040, !br, br ? 8'h40 : pc + 8'd1, "brz_taken");
    alu_op(16'h1000, 0, 1'b0, 2'd0, 2'd0, 2'd0, 4'h1, "sub_z0");
    flow_op(16'h6040, !br, pc + 8'd1, "brz_not_taken");
    flow_op(16'h70FF, !br, br ? 8'hFF : pc + 8'd1, "jmp");

    while (pc != 8'hFF) flow_op(16'h8000, 1'b0, pc + 8'd1, "nop");
    flow_op(16'h8000, 1'b0, 8'h00, "pc_wrap");

    flow_op(16'hA000, 1'b1, 8'h01, "op_a");

    // HALT at 01
    fetch(16'hF000, 0, "halt");
    @(negedge clk);
    @(negedge clk);
    req_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (IMem_Req) req_cnt++;
      @(negedge clk);
    end
    check("halt_halted", Halted, 1);
    check("halt_req_cycles", req_cnt, 0);
    check("halt_we", RF_WE, 0);

    rst_n = 1'b0;
    #1;
    check("halt_rst_halted", Halted, 0);
    check("halt_rst_addr", IMem_Addr, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    pc = 8'h00;
    @(negedge clk);
    check("rerun_req", IMem_Req, 1);

    // Reset mid-fetch with a late Ack held across release
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_req", IMem_Req, 0);
    check("midrst_we", RF_WE, 0);
    IMem_Data = 16'h5CAA;
    IMem_Ack  = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    IMem_Ack  = 1'b0;
    IMem_Data = 16'h0000;
    check("late_ack_req", IMem_Req, 1);
    check("late_ack_addr", IMem_Addr, 8'h00);
    check("late_ack_imm", Imm, 8'h00);
    we_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (RF_WE || !IMem_Req) we_cnt++;
      @(negedge clk);
    end
    check("late_ack_idle", we_cnt, 0);
    alu_op(16'h2E40, 0, 1'b0, 2'd3, 2'd2, 2'd1, 4'h2, "and_after_rst");
    check("and_next_addr", IMem_Addr, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
